pkt_axi_wr_master: RTL and testbench

AXI4 write initiator that drains a UDP byte stream (AXI-Stream, 8-bit tdata) and writes it as 32-bit INCR bursts into an AXI slave, normally the OutFIFO slave port. It is the initiator-side counterpart of the packet FIFO slave interface. It packs bytes into words with byte strobes, buffers one burst locally, and issues AW, W and B in sequence. It signals a done pulse per packet.

---
 rtl/pkt_axi_wr_master.sv | 189 ++++++++++++++++++
 tb/tb_pkt_axi_wr_master.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_axi_wr_master.sv
// AXI4 write initiator: packs an 8-bit AXI-Stream packet into 32-bit INCR bursts
// of up to MAX_BURST beats, writes them at BASE_ADDR onward and pulses done/err per packet.
module pkt_axi_wr_master #(
  parameter logic [31:0]     BASE_ADDR = 32'h0,
  parameter int unsigned     MAX_BURST = 16,
  parameter int unsigned     ID_W      = 4,
  parameter logic [ID_W-1:0] AXI_ID    = '0
) (
  input  logic            clk_axi,
  input  logic            rst_axi,
  // byte stream in
  input  logic [7:0]      axis_sin_tdata,
  input  logic            axis_sin_tvalid,
  input  logic            axis_sin_tlast,
  output logic            axis_sin_tready,
  // AXI write address
  output logic [ID_W-1:0] axi_awid,
  output logic [31:0]     axi_awaddr,
  output logic [7:0]      axi_awlen,
  output logic [2:0]      axi_awsize,
  output logic [1:0]      axi_awburst,
  output logic            axi_awvalid,
  input  logic            axi_awready,
  // AXI write data
  output logic [31:0]     axi_wdata,
  output logic [3:0]      axi_wstrb,
  output logic            axi_wlast,
  output logic            axi_wvalid,
  input  logic            axi_wready,
  // AXI write response
  input  logic [ID_W-1:0] axi_bid,
  input  logic [1:0]      axi_bresp,
  input  logic            axi_bvalid,
  output logic            axi_bready,
  // read side is never used
  output logic            axi_arvalid,
  output logic            axi_rready,
  // per-packet status
  output logic            done_o,
  output logic            err_o
);

  localparam int WC_W  = $clog2(MAX_BURST) + 1;
  localparam int IDX_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [WC_W-1:0] ONE       = WC_W'(1);
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(MAX_BURST - 1);
  localparam logic [1:0]      AXI_OKAY  = 2'b00;

  typedef enum logic [1:0] {FILL_ST, AW_ST, W_ST, B_ST} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WC_W-1:0]   r_word_cnt;
  logic [1:0]        r_byte_cnt;
  logic [WC_W-1:0]   r_beat;
  logic [31:0]       r_addr;
  logic              r_err_acc;
  logic              r_pkt_last;
  logic              r_done;
  logic              r_err;
  logic [31:0]       r_buf_data [DEPTH];
  logic [3:0]        r_buf_strb [DEPTH];

  logic              w_tready;
  logic              w_acc;
  logic              w_word_done;
  logic              w_fill_done;
  logic              w_beat_last;
  logic              w_bresp_err;
  logic [IDX_W-1:0]  w_fill_idx;
  logic [IDX_W-1:0]  w_beat_idx;
  logic              w_unused_bid;

  assign w_tready    = rst_axi && (r_state == FILL_ST);
  assign w_acc       = axis_sin_tvalid && w_tready;
  assign w_word_done = w_acc && (axis_sin_tlast || (r_byte_cnt == 2'd3));
  assign w_fill_done = w_acc && (axis_sin_tlast ||
                                 ((r_byte_cnt == 2'd3) && (r_word_cnt == LAST_WORD)));
  assign w_beat_last = (r_beat == (r_word_cnt - ONE));
  assign w_bresp_err = (axi_bresp != AXI_OKAY);
  assign w_fill_idx  = r_word_cnt[IDX_W-1:0];
  assign w_beat_idx  = r_beat[IDX_W-1:0];
  assign w_unused_bid = ^axi_bid;

  // NOTE: every output and next-state variable gets a default first so no latch is inferred.
  always_comb begin
    w_next      = r_state;
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    axi_bready  = 1'b0;
    if (rst_axi) begin
      case (r_state)
        FILL_ST: if (w_fill_done) w_next = AW_ST;
        AW_ST: begin
          axi_awvalid = 1'b1;
          if (axi_awready) w_next = W_ST;
        end
        W_ST: begin
          axi_wvalid = 1'b1;
          if (axi_wready && w_beat_last) w_next = B_ST;
        end
        B_ST: begin
          axi_bready = 1'b1;
          if (axi_bvalid) w_next = FILL_ST;
        end
        default: w_next = FILL_ST;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_axi) begin
    if (!rst_axi) r_state <= FILL_ST;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk_axi) begin
    if (!rst_axi) begin
      r_word_cnt <= '0;
      r_byte_cnt <= 2'd0;
      r_beat     <= '0;
      r_addr     <= BASE_ADDR;
      r_err_acc  <= 1'b0;
      r_pkt_last <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        FILL_ST: begin
          r_beat <= '0;
          if (w_acc) begin
            r_byte_cnt <= axis_sin_tlast ? 2'd0 : r_byte_cnt + 2'd1;
            if (w_word_done) r_word_cnt <= r_word_cnt + ONE;
            if (w_fill_done) r_pkt_last <= axis_sin_tlast;
          end
        end
        W_ST: if (axi_wvalid && axi_wready) r_beat <= r_beat + ONE;
        B_ST: begin
          if (axi_bvalid && axi_bready) begin
            r_word_cnt <= '0;
            r_byte_cnt <= 2'd0;
            if (r_pkt_last) begin
              r_done    <= 1'b1;
              r_err     <= r_err_acc | w_bresp_err;
              r_err_acc <= 1'b0;
              r_addr    <= BASE_ADDR;
            end else begin
              r_err_acc <= r_err_acc | w_bresp_err;
              r_addr    <= r_addr + 32'({r_word_cnt, 2'b00});
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the buffer has no reset; a lane-0 write reinitialises the whole word, so stale
  // contents are never sent and resetting the array would only cost flops.
  always_ff @(posedge clk_axi) begin
    if (w_acc) begin
      if (r_byte_cnt == 2'd0) begin
        r_buf_data[w_fill_idx] <= {24'h0, axis_sin_tdata};
        r_buf_strb[w_fill_idx] <= 4'b0001;
      end else begin
        r_buf_data[w_fill_idx][{r_byte_cnt, 3'b000} +: 8] <= axis_sin_tdata;
        r_buf_strb[w_fill_idx][r_byte_cnt]                <= 1'b1;
      end
    end
  end

  assign axis_sin_tready = w_tready;
  assign axi_awid        = AXI_ID;
  assign axi_awaddr      = r_addr;
  assign axi_awlen       = 8'(r_word_cnt - ONE);
  assign axi_awsize      = 3'd2;
  assign axi_awburst     = 2'b01;
  assign axi_wdata       = r_buf_data[w_beat_idx];
  assign axi_wstrb       = r_buf_strb[w_beat_idx];
  assign axi_wlast       = axi_wvalid && w_beat_last;
  assign axi_arvalid     = 1'b0;
  assign axi_rready      = 1'b0;
  assign done_o          = r_done;
  assign err_o           = r_err;

endmodule

// File: tb/tb_pkt_axi_wr_master.sv
// Bench for pkt_axi_wr_master: a responsive AXI slave with configurable stalls/errors,
// a table of packet scenarios, random packets, and a mid-burst reset sequence.
module tb_pkt_axi_wr_master;

  localparam logic [31:0] BASE = 32'h100;
  localparam int          MAXB = 16;
  localparam logic [3:0]  ID   = 4'h5;

  logic        clk_axi = 1'b0;
  logic        rst_axi;
  logic [7:0]  axis_sin_tdata;
  logic        axis_sin_tvalid;
  logic        axis_sin_tlast;
  logic        axis_sin_tready;
  logic [3:0]  axi_awid;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [3:0]  axi_bid;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  logic        axi_arvalid;
  logic        axi_rready;
  logic        done_o;
  logic        err_o;

  pkt_axi_wr_master #(
    .BASE_ADDR(BASE), .MAX_BURST(MAXB), .ID_W(4), .AXI_ID(ID)
  ) dut (
    .clk_axi(clk_axi), .rst_axi(rst_axi),
    .axis_sin_tdata(axis_sin_tdata), .axis_sin_tvalid(axis_sin_tvalid),
    .axis_sin_tlast(axis_sin_tlast), .axis_sin_tready(axis_sin_tready),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready), .axi_arvalid(axi_arvalid), .axi_rready(axi_rready),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_axi = ~clk_axi;

  int n_vec;
  int n_err;

  // slave configuration, written only by the main sequence
  int cfg_aw_wait;
  bit cfg_w_toggle;
  int cfg_err_burst;

  // observed traffic: AW {addr,len}, W {data,strb,last}, done events carrying err_o
  logic [39:0] aw_q[$];
  logic [36:0] w_q[$];
  logic        done_q[$];
  logic [7:0]  pkt_q[$];

  typedef struct {
    int len;
    int aw_wait;
    bit w_toggle;
    int err_burst;
    int exp_bursts;
    bit exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // AXI slave and monitor: decides ready/valid at the falling edge, records handshakes
  initial begin : slave
    int          aw_hold;
    bit          w_tog;
    bit          w_pend;
    int          b_idx;
    logic [31:0] aw_addr0;
    logic [7:0]  aw_len0;
    logic [36:0] w_prev;
    logic [36:0] w_cur;
    aw_hold = 0; w_tog = 1'b0; w_pend = 1'b0; b_idx = 0;
    aw_addr0 = '0; aw_len0 = '0; w_prev = '0;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0;
    axi_bresp = 2'b00; axi_bid = 4'h0;
    forever begin
      @(negedge clk_axi);
      axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;
      if (!rst_axi) begin
        aw_hold = 0; b_idx = 0; w_tog = 1'b0; w_pend = 1'b0;
      end else begin
        if (axi_awvalid) begin
          check("aw_w_exclusive", axi_wvalid, 1'b0);
          check("tready_low_in_aw", axis_sin_tready, 1'b0);
          if (aw_hold == 0) begin
            aw_addr0 = axi_awaddr; aw_len0 = axi_awlen;
          end else begin
            check("awaddr_stable", axi_awaddr, aw_addr0);
            check("awlen_stable", axi_awlen, aw_len0);
          end
          if (aw_hold >= cfg_aw_wait) begin
            axi_awready = 1'b1;
            check("awid", axi_awid, ID);
            check("awsize", axi_awsize, 3'd2);
            check("awburst", axi_awburst, 2'b01);
            aw_q.push_back({axi_awaddr, axi_awlen});
            aw_hold = 0;
          end else begin
            aw_hold++;
          end
        end
        if (axi_wvalid) begin
          w_cur = {axi_wdata, axi_wstrb, axi_wlast};
          if (w_pend) check("w_stable", w_cur, w_prev);
          w_tog = !w_tog;
          if (!cfg_w_toggle || w_tog) begin
            axi_wready = 1'b1;
            w_q.push_back(w_cur);
            w_pend = 1'b0;
          end else begin
            w_pend = 1'b1;
            w_prev = w_cur;
          end
        end else begin
          w_pend = 1'b0;
        end
        if (axi_bready) begin
          axi_bvalid = 1'b1;
          axi_bid    = 4'($urandom);
          axi_bresp  = (b_idx == cfg_err_burst) ? 2'b10 : 2'b00;
          b_idx++;
        end
        if (done_o) begin
          check("tready_with_done", axis_sin_tready, 1'b1);
          done_q.push_back(err_o);
          b_idx = 0;
        end
      end
    end
  end

  // drive pkt_q one byte per accepted cycle; starts and ends at a falling edge
  task automatic send_bytes();
    int n;
    int w;
    n = pkt_q.size();
    for (int i = 0; i < n; i++) begin
      axis_sin_tdata  = pkt_q[i];
      axis_sin_tvalid = 1'b1;
      axis_sin_tlast  = (i == n - 1);
      w = 0;
      while (!axis_sin_tready && w < 5000) begin
        @(negedge clk_axi);
        w++;
      end
      if (w >= 5000) begin
        check("tready_timeout", 1'b0, 1'b1);
        axis_sin_tvalid = 1'b0;
        return;
      end
      @(negedge clk_axi);
    end
    axis_sin_tvalid = 1'b0;
    axis_sin_tlast  = 1'b0;
    check("awvalid_after_last_byte", axi_awvalid, 1'b1);
  endtask

  // send a packet, wait for its done pulse, compare all traffic against the packing model
  task automatic run_packet(input int exp_bursts, input bit exp_err);
    int n;
    int words;
    int t;
    int nb_cmp;
    int nw_cmp;
    n = pkt_q.size();
    words = (n + 3) / 4;
    aw_q.delete(); w_q.delete(); done_q.delete();
    send_bytes();
    t = 0;
    while (done_q.size() == 0 && t < 5000) begin
      @(negedge clk_axi);
      t++;
    end
    repeat (3) @(negedge clk_axi);
    check("done_pulses", done_q.size(), 1);
    if (done_q.size() > 0) check("err_o", done_q[0], exp_err);
    check("burst_count", aw_q.size(), exp_bursts);
    nb_cmp = (aw_q.size() < exp_bursts) ? aw_q.size() : exp_bursts;
    for (int k = 0; k < nb_cmp; k++) begin
      int beats;
      beats = words - k * MAXB;
      if (beats > MAXB) beats = MAXB;
      check("awaddr", aw_q[k][39:8], BASE + 32'(k * MAXB * 4));
      check("awlen", aw_q[k][7:0], 8'(beats - 1));
    end
    check("beat_count", w_q.size(), words);
    nw_cmp = (w_q.size() < words) ? w_q.size() : words;
    for (int w = 0; w < nw_cmp; w++) begin
      int          cnt;
      logic [31:0] d;
      logic [31:0] m;
      logic [3:0]  s;
      cnt = n - 4 * w;
      if (cnt > 4) cnt = 4;
      d = '0; m = '0; s = '0;
      for (int b = 0; b < cnt; b++) begin
        d[8*b +: 8] = pkt_q[4*w + b];
        m[8*b +: 8] = 8'hFF;
        s[b]        = 1'b1;
      end
      check("wdata", w_q[w][36:5] & m, d);
      check("wstrb", w_q[w][4:1], s);
      check("wlast", w_q[w][0], ((w % MAXB) == MAXB - 1) || (w == words - 1));
    end
  endtask

  task automatic fill_random(input int len);
    pkt_q.delete();
    for (int i = 0; i < len; i++) pkt_q.push_back(8'($urandom));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int t;
    n_vec = 0; n_err = 0;
    cfg_aw_wait = 0; cfg_w_toggle = 1'b0; cfg_err_burst = -1;
    axis_sin_tdata = 8'h00; axis_sin_tvalid = 1'b0; axis_sin_tlast = 1'b0;

    vecs[0] = '{4,   0, 1'b0, -1, 1, 1'b0};
    vecs[1] = '{5,   0, 1'b0, -1, 1, 1'b0};
    vecs[2] = '{70,  0, 1'b0, -1, 2, 1'b0};
    vecs[3] = '{70,  0, 1'b0,  0, 2, 1'b1};
    vecs[4] = '{4,   0, 1'b0, -1, 1, 1'b0};
    vecs[5] = '{64,  0, 1'b0, -1, 1, 1'b0};
    vecs[6] = '{1,   0, 1'b0, -1, 1, 1'b0};
    vecs[7] = '{37,  5, 1'b1, -1, 1, 1'b0};
    vecs[8] = '{130, 2, 1'b1,  2, 3, 1'b1};
    vecs[9] = '{3,   0, 1'b0,  0, 1, 1'b1};

    rst_axi = 1'b0;
    repeat (3) @(negedge clk_axi);
    check("rst_tready", axis_sin_tready, 1'b0);
    check("rst_awvalid", axi_awvalid, 1'b0);
    check("rst_wvalid", axi_wvalid, 1'b0);
    check("rst_wlast", axi_wlast, 1'b0);
    check("rst_bready", axi_bready, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("arvalid_tied", axi_arvalid, 1'b0);
    check("rready_tied", axi_rready, 1'b0);
    rst_axi = 1'b1;
    @(negedge clk_axi);
    check("tready_after_reset", axis_sin_tready, 1'b1);

    pkt_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_packet(1, 1'b0);
    if (aw_q.size() == 1) check("aabbccdd_awaddr", aw_q[0][39:8], 32'h100);
    if (w_q.size() == 1) begin
      check("aabbccdd_wdata", w_q[0][36:5], 32'hDDCCBBAA);
      check("aabbccdd_wstrb", w_q[0][4:1], 4'b1111);
    end

    for (int v = 0; v < 10; v++) begin
      cfg_aw_wait = vecs[v].aw_wait;
      cfg_w_toggle = vecs[v].w_toggle;
      cfg_err_burst = vecs[v].err_burst;
      fill_random(vecs[v].len);
      run_packet(vecs[v].exp_bursts, vecs[v].exp_err);
    end

    for (int r = 0; r < 8; r++) begin
      int len;
      int words;
      int nb;
      len = int'($urandom_range(1, 150));
      words = (len + 3) / 4;
      nb = (words + MAXB - 1) / MAXB;
      cfg_aw_wait = int'($urandom_range(0, 3));
      cfg_w_toggle = 1'($urandom_range(0, 1));
      cfg_err_burst = int'($urandom_range(0, 3)) - 1;
      fill_random(len);
      run_packet(nb, (cfg_err_burst >= 0) && (cfg_err_burst < nb));
    end

    // reset while the W beats of a 5-beat burst are in flight
    cfg_aw_wait = 0; cfg_w_toggle = 1'b1; cfg_err_burst = -1;
    fill_random(20);
    aw_q.delete(); w_q.delete(); done_q.delete();
    send_bytes();
    t = 0;
    while (w_q.size() < 3 && t < 2000) begin
      @(negedge clk_axi);
      t++;
    end
    check("reached_beat3", w_q.size() >= 3, 1'b1);
    rst_axi = 1'b0;
    @(negedge clk_axi);
    check("midrst_wvalid", axi_wvalid, 1'b0);
    check("midrst_awvalid", axi_awvalid, 1'b0);
    check("midrst_tready", axis_sin_tready, 1'b0);
    @(negedge clk_axi);
    rst_axi = 1'b1;
    @(negedge clk_axi);
    check("midrst_tready_after", axis_sin_tready, 1'b1);
    check("midrst_no_done", done_q.size(), 0);
    cfg_w_toggle = 1'b0;
    fill_random(4);
    run_packet(1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
